// File: rtl/boa_pkg.sv
`default_nettype none
// ============================================================================
// boa_pkg
// Shared constants and types for the boa instruction-fetch front end.
// Revision: 1.0
// ============================================================================
package boa_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        trap;
    } boa_if_entry_t;

    typedef enum logic [3:0] {
        TRAP_INSN_MISALIGNED = 4'd0
    } boa_trap_cause_e;

    localparam boa_if_entry_t IF_ENTRY_RESET = '{pc: 32'h0, insn: RV_NOP, trap: 1'b0};

endpackage
`default_nettype wire

// File: rtl/boa_skid_buf.sv
`default_nettype none
// ============================================================================
// boa_skid_buf
// Output register plus one-entry skid, order-preserving valid/ready buffer.
// Revision: 1.0
// ============================================================================
module boa_skid_buf #(
    parameter type T         = logic,
    parameter T    RESET_VAL = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_flush,
    input  logic i_valid,
    input  T     i_data,
    input  logic i_ready,
    output logic o_valid,
    output T     o_data,
    output logic o_skid_valid
);

    logic r_out_valid;
    logic r_skid_valid;
    T     r_out;
    T     r_skid;
    logic w_out_free;

    assign w_out_free = !r_out_valid || i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out        <= RESET_VAL;
            r_skid       <= RESET_VAL;
        end else if (i_flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            // The skid holds the older entry, so it always moves up first.
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= i_valid;
                if (i_valid) begin
                    r_skid <= i_data;
                end
            end else begin
                r_out_valid <= i_valid;
                if (i_valid) begin
                    r_out <= i_data;
                end
            end
        end else if (i_valid) begin
            r_skid       <= i_data;
            r_skid_valid <= 1'b1;
        end
    end

    assign o_valid      = r_out_valid;
    assign o_data       = r_out;
    assign o_skid_valid = r_skid_valid;

endmodule
`default_nettype wire

// File: rtl/boa_stage_if.sv
`default_nettype none
// ============================================================================
// boa_stage_if
// RV32 fetch stage: owns the PC, issues word fetches, feeds ID via skid buffer.
// Revision: 1.0
// ============================================================================
module boa_stage_if
    import boa_pkg::*;
#(
    parameter logic [31:0] ENTRY_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        fw_branch,
    input  logic [31:0] fw_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_insn,
    output logic        id_trap
);

    logic [31:0]   r_pc;
    logic [31:0]   r_pend_pc;
    logic          r_pend;
    logic          r_pend_trap;
    logic          r_halt;

    logic          w_out_valid;
    logic          w_skid_valid;
    boa_if_entry_t w_out;
    boa_if_entry_t w_resp;
    logic          w_resp_valid;
    logic [1:0]    w_occ;
    logic          w_issue_ok;
    logic          w_misaligned;
    logic          w_accept;
    logic          w_trap_issue;

    always_comb begin
        // Entries that will still need a slot after this cycle's ID handshake.
        w_occ        = {1'b0, w_out_valid && !id_ready} + {1'b0, w_skid_valid} + {1'b0, r_pend};
        w_issue_ok   = !r_halt && !fw_branch && !rst && (w_occ < 2'd2);
        w_misaligned = (r_pc[1:0] != 2'b00);
        mem_re       = w_issue_ok && !w_misaligned;
        w_trap_issue = w_issue_ok && w_misaligned;
        w_accept     = mem_re && mem_ready;
        w_resp_valid = r_pend && !fw_branch;
        w_resp.pc    = r_pend_pc;
        w_resp.insn  = r_pend_trap ? RV_NOP : mem_rdata;
        w_resp.trap  = r_pend_trap;
    end

    assign mem_addr = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= ENTRY_PC;
            r_pend_pc   <= 32'h0;
            r_pend      <= 1'b0;
            r_pend_trap <= 1'b0;
            r_halt      <= 1'b0;
        end else if (fw_branch) begin
            r_pc   <= fw_target;
            r_pend <= 1'b0;
            r_halt <= 1'b0;
        end else begin
            // A misaligned PC occupies the pending slot like a real fetch would.
            r_pend      <= w_accept || w_trap_issue;
            r_pend_trap <= w_trap_issue;
            r_pend_pc   <= r_pc;
            if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_trap_issue) begin
                r_halt <= 1'b1;
            end
        end
    end

    boa_skid_buf #(
        .T         (boa_if_entry_t),
        .RESET_VAL (IF_ENTRY_RESET)
    ) u_skid (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (fw_branch),
        .i_valid      (w_resp_valid),
        .i_data       (w_resp),
        .i_ready      (id_ready),
        .o_valid      (w_out_valid),
        .o_data       (w_out),
        .o_skid_valid (w_skid_valid)
    );

    assign id_valid = w_out_valid;
    assign id_pc    = w_out.pc;
    assign id_insn  = w_out.insn;
    assign id_trap  = w_out.trap;

endmodule
`default_nettype wire
